timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  Memory-mapped programmable down-counter timer with interrupt request output.
//  Sits on the CPU data bus behind the bridge as a peripheral.
//  Its irq output drives the mips top-level interrupt input directly.
//  Provides one-shot and auto-reload periodic interrupts for exception-handler tests.
// PARAMETERS
//  WIDTH  32  width of PRESET and COUNT registers (the bus is always 32 bits; upper bits read 0)
// PORTS
//  clk    in   1      system clock; all state updates on posedge
//  reset  in   1      asynchronous, active-high; clears all state immediately
//  addr   in   2      word select (bus addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//  we     in   1      write enable for the selected register, sampled at posedge
//  wdata  in   32     write data
//  rdata  out  32     read data, combinational from addr
//  irq    out  1      interrupt request to the CPU = CTRL.IM & irq_flag
// BEHAVIOUR
//  Registers
//  - CTRL[3:0]: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x = one-shot), bit3 IM.
//  - CTRL[31:4] reads 0. PRESET is read/write. COUNT is read-only; writes to addr 2 and addr 3 are ignored.
//  - rdata: addr 0 -> {28'b0, CTRL}; 1 -> PRESET; 2 -> COUNT; 3 -> 32'b0.
//  Reset values
//  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
//  - So irq=0 and rdata=0 for every addr.
//  FSM: IDLE, LOAD, CNT, INT
//  - IDLE: if EN -> LOAD; otherwise hold. COUNT holds.
//  - LOAD: COUNT <= PRESET; -> CNT.
//  - CNT, EN=0: -> IDLE; COUNT frozen.
//  - CNT, EN=1, COUNT!=0: COUNT <= COUNT-1.
//  - CNT, EN=1, COUNT==0: irq_flag <= 1; -> INT.
//  - INT, one-shot: EN <= 0; -> IDLE. irq_flag stays 1.
//  - INT, auto-reload: irq_flag <= 0; -> LOAD.
//  Timing (PRESET=N, EN written at edge 0)
//  - LOAD at edge 1, COUNT=N after edge 2, COUNT=0 after edge N+2.
//  - irq rises after edge N+3.
//  - Auto-reload: irq is high for exactly 1 cycle, with period N+3 cycles.
//  - One-shot: irq stays high until CTRL is written.
//  Bus-write rules
//  - Any CTRL write clears irq_flag.
//  - A bus write to CTRL wins over FSM updates in the same cycle: the written EN wins over INT clearing EN, and the clear wins over INT setting irq_flag.
//  - A PRESET write never touches COUNT; it takes effect at the next LOAD.
//  - Disabling mid-count and then re-enabling restarts from PRESET; counting does not resume.
//  - PRESET=0: INT is reached 3 cycles after EN (auto-reload period 3).
//  - A MODE change while counting applies at the next INT.
//  - IM=0 masks irq only; irq_flag still sets. Setting IM later exposes a pending flag at once.
//  - No wrap-around: COUNT never decrements below 0.
//  - Asserting reset mid-count forces IDLE and irq=0 immediately, without waiting for clk.
// TESTING
//  - Reset: hold reset 20ns, read addr 0..3 -> all 0; irq=0 throughout.
//  - One-shot: PRESET=5, CTRL=0x9 -> irq rises 8 cycles after the CTRL write and stays high; COUNT=0; CTRL reads 0x8.
//    Then write CTRL=0 -> irq falls next cycle.
//  - Auto-reload: PRESET=2, CTRL=0xB -> irq is a 1-cycle pulse every 5 cycles over 4 periods; COUNT sequence 2,1,0.
//  - Disable mid-count: PRESET=10, enable, clear EN when COUNT=6 -> COUNT holds 6, no irq.
//    Re-enable -> COUNT reloads 10.
//  - Mask: PRESET=3, CTRL=0x1 -> irq stays 0 and state returns to IDLE.
//    Write CTRL=0x8 -> irq stays 0, because the flag is cleared by the write.
//  - Async reset: assert reset mid-period between clock edges in auto-reload -> irq=0 and COUNT=0 before the next posedge.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with a maskable interrupt request.
// One-shot and auto-reload modes; COUNT is loaded from PRESET on every (re)start.
module timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied last so they override the FSM's EN clear and flag set.
    if (we) begin
      unique case (addr)
        2'd0: begin
          ctrl_d = wdata[3:0];
          flag_d = 1'b0;
        end
        2'd1:    preset_d = wdata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0:    rdata = {28'b0, ctrl_q};
      2'd1:    rdata = 32'(preset_q);
      2'd2:    rdata = 32'(count_q);
      default: rdata = '0;
    endcase
  end

  assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios with literal expectations plus
// randomized bus traffic, all checked every cycle against a behavioural model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int passes = 0;

  timer_counter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // phase: 0 idle, 1 about to load, 2 counting, 3 expired
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic [1:0]  phase;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic w, logic [1:0] a, logic [31:0] d);
    mdl_t n = s;
    bit en     = s.ctrl[0];
    bit reload = (s.ctrl[2:1] == 2'b01);
    if (s.phase == 2'd0) begin
      if (en) n.phase = 2'd1;
    end else if (s.phase == 2'd1) begin
      n.count = s.preset;
      n.phase = 2'd2;
    end else if (s.phase == 2'd2) begin
      if (!en) n.phase = 2'd0;
      else if (s.count > 0) n.count = s.count - 1;
      else begin
        n.flag  = 1'b1;
        n.phase = 2'd3;
      end
    end else begin
      if (reload) begin
        n.flag  = 1'b0;
        n.phase = 2'd1;
      end else begin
        n.ctrl[0] = 1'b0;
        n.phase   = 2'd0;
      end
    end
    if (w && a == 2'd0) begin
      n.ctrl = d[3:0];
      n.flag = 1'b0;
    end
    if (w && a == 2'd1) n.preset = d;
    return n;
  endfunction

  function automatic logic [31:0] mread(mdl_t s, logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, we, addr, wdata);
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  always @(negedge clk) begin
    chk("model_irq", {31'b0, irq}, {31'b0, m.ctrl[3] & m.flag});
    chk("model_rdata", rdata, mread(m, addr));
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rdchk(string name, logic [1:0] a, logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    int k;
    int nhi;
    int rise[4];
    bit found;
    bit hi;

    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;

    // Reset held for 20ns: every register reads zero
    #6;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
    end
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // One-shot: PRESET=5, CTRL=IM|EN
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (irq) begin
        k = i;
        break;
      end
    end
    chk("oneshot_rise_cycle", k, 8);
    tick(3);
    chk("oneshot_irq_held", {31'b0, irq}, 32'h1);
    rdchk("oneshot_count", 2'd2, 32'h0);
    rdchk("oneshot_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h0);
    chk("oneshot_irq_cleared", {31'b0, irq}, 32'h0);

    // Auto-reload: PRESET=2, CTRL=IM|MODE01|EN
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    nhi  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i >= 2 && i <= 4) chk("reload_count_seq", rdata, 32'(4 - i));
      if (irq) begin
        if (nhi < 4) rise[nhi] = i;
        nhi++;
      end
    end
    chk("reload_pulse_count", nhi, 4);
    for (int p = 0; p < 4; p++) chk("reload_pulse_cycle", rise[p], 5 * (p + 1));
    wr(2'd0, 32'h0);
    tick(3);

    // Disable mid-count, then re-enable restarts from PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    addr  = 2'd2;
    found = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (rdata == 32'd7) begin
        found = 1'b1;
        break;
      end
    end
    chk("disable_reached_7", {31'b0, found}, 32'h1);
    wr(2'd0, 32'h0);
    rdchk("disable_count_6", 2'd2, 32'd6);
    tick(4);
    chk("disable_count_held", rdata, 32'd6);
    chk("disable_no_irq", {31'b0, irq}, 32'h0);
    wr(2'd0, 32'h1);
    addr = 2'd2;
    tick(2);
    chk("reenable_reload", rdata, 32'd10);
    wr(2'd0, 32'h0);
    tick(3);

    // Masked one-shot: flag sets silently; a later CTRL write clears it
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    hi = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (irq) hi = 1'b1;
    end
    chk("mask_irq_low", {31'b0, hi}, 32'h0);
    rdchk("mask_ctrl_en_cleared", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("mask_write_irq", {31'b0, irq}, 32'h0);
    tick(2);
    chk("mask_write_irq_later", {31'b0, irq}, 32'h0);
    wr(2'd0, 32'h0);

    // Asynchronous reset while an auto-reload pulse is high
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    tick(5);
    chk("areset_pre_irq", {31'b0, irq}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_irq", {31'b0, irq}, 32'h0);
    chk("areset_count", rdata, 32'h0);
    rdchk("areset_ctrl", 2'd0, 32'h0);
    rdchk("areset_preset", 2'd1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized bus traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      addr  = 2'($urandom_range(0, 3));
      we    = ($urandom_range(0, 7) == 0);
      wdata = (addr == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    we = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
